// File: rtl/data_island_scheduler.sv
// data_island_scheduler
//   Picks the packet that fills each HDMI data-island slot. Audio samples have
//   the highest priority, then ACR, then the AVI, Audio and SPD InfoFrames.
//   When nothing is pending the slot carries a null packet. The chosen header
//   and subpackets are registered once per slot.
//
// Ports
//   clk_pixel          pixel clock (sole clock)
//   reset              synchronous, active-high reset
//   frame_start        one-cycle pulse at the start of each video frame
//   packet_enable      one-cycle pulse at the start of each packet slot
//   sample_valid       audio sample packet available (level)
//   acr_req            one-cycle ACR request pulse
//   *_header / *_sub   header (24b) and four 56b subpackets per source
//   sample_ack         sample packet taken this slot (combinational)
//   header / sub       registered packet for the current slot
//   packet_type        header[7:0]; 0x00 is the null packet
//   infoframe_missed   a frame started with an InfoFrame still unsent
module data_island_scheduler #(
   parameter int unsigned SPD_FRAMES = 1
) (
   input  logic              clk_pixel,
   input  logic              reset,
   input  logic              frame_start,
   input  logic              packet_enable,
   input  logic              sample_valid,
   input  logic              acr_req,
   input  logic [23:0]       sample_header,
   input  logic [3:0][55:0]  sample_sub,
   input  logic [23:0]       acr_header,
   input  logic [3:0][55:0]  acr_sub,
   input  logic [23:0]       avi_header,
   input  logic [3:0][55:0]  avi_sub,
   input  logic [23:0]       aif_header,
   input  logic [3:0][55:0]  aif_sub,
   input  logic [23:0]       spd_header,
   input  logic [3:0][55:0]  spd_sub,
   output logic              sample_ack,
   output logic [23:0]       header,
   output logic [3:0][55:0]  sub,
   output logic [7:0]        packet_type,
   output logic              infoframe_missed
);

   localparam logic [7:0] FCNT_LAST = 8'(SPD_FRAMES - 1);

   typedef enum logic [2:0] {
      SRC_NONE,
      SRC_NULL,
      SRC_SAMPLE,
      SRC_ACR,
      SRC_AVI,
      SRC_AIF,
      SRC_SPD
   } src_t;

   logic       avi_p, aif_p, spd_p, acr_p;
   logic [7:0] fcnt;
   src_t       sel;

   logic             g_acr, g_avi, g_aif, g_spd;
   logic [23:0]      sel_header;
   logic [3:0][55:0] sel_sub;

   // Slot arbitration; SRC_NONE means no slot starts this cycle.
   always_comb begin
      sel = SRC_NONE;
      if (packet_enable && !reset) begin
         if (sample_valid)          sel = SRC_SAMPLE;
         else if (acr_p || acr_req) sel = SRC_ACR;
         else if (avi_p)            sel = SRC_AVI;
         else if (aif_p)            sel = SRC_AIF;
         else if (spd_p)            sel = SRC_SPD;
         else                       sel = SRC_NULL;
      end
   end

   always_comb begin
      sel_header = '0;
      sel_sub    = '0;
      case (sel)
         SRC_SAMPLE: begin sel_header = sample_header; sel_sub = sample_sub; end
         SRC_ACR:    begin sel_header = acr_header;    sel_sub = acr_sub;    end
         SRC_AVI:    begin sel_header = avi_header;    sel_sub = avi_sub;    end
         SRC_AIF:    begin sel_header = aif_header;    sel_sub = aif_sub;    end
         SRC_SPD:    begin sel_header = spd_header;    sel_sub = spd_sub;    end
         default:    begin sel_header = '0;            sel_sub = '0;         end
      endcase
   end

   assign g_acr      = (sel == SRC_ACR);
   assign g_avi      = (sel == SRC_AVI);
   assign g_aif      = (sel == SRC_AIF);
   assign g_spd      = (sel == SRC_SPD);
   assign sample_ack = (sel == SRC_SAMPLE);

   assign packet_type = header[7:0];

   always_ff @(posedge clk_pixel) begin
      if (reset) begin
         avi_p            <= 1'b0;
         aif_p            <= 1'b0;
         spd_p            <= 1'b0;
         acr_p            <= 1'b0;
         fcnt             <= '0;
         header           <= '0;
         sub              <= '0;
         infoframe_missed <= 1'b0;
      end else begin
         if (sel != SRC_NONE) begin
            header <= sel_header;
            sub    <= sel_sub;
         end

         // A grant served by this cycle's request leaves nothing pending; a
         // grant served by an older request keeps a coincident new one.
         if (g_acr) acr_p <= acr_p & acr_req;
         else       acr_p <= acr_p | acr_req;

         // frame_start sets win over a coincident grant: the grant consumed
         // the previous frame's flag, the set belongs to the new frame.
         avi_p <= frame_start | (avi_p & ~g_avi);
         aif_p <= frame_start | (aif_p & ~g_aif);
         spd_p <= (frame_start && fcnt == '0) | (spd_p & ~g_spd);

         infoframe_missed <= frame_start &
                             ((avi_p & ~g_avi) | (aif_p & ~g_aif) | (spd_p & ~g_spd));

         if (frame_start) begin
            if (fcnt >= FCNT_LAST) fcnt <= '0;
            else                   fcnt <= fcnt + 8'd1;
         end
      end
   end

endmodule

// File: tb/tb_data_island_scheduler.sv
// Directed bench for data_island_scheduler (SPD_FRAMES=3). Each slot pushes
// its expected packet into a scoreboard queue; the entry is popped and
// compared once the registered outputs update after the slot edge.
module tb_data_island_scheduler;

   logic             clk_pixel = 1'b0;
   logic             reset = 1'b1;
   logic             frame_start = 1'b0;
   logic             packet_enable = 1'b0;
   logic             sample_valid = 1'b0;
   logic             acr_req = 1'b0;
   logic [23:0]      sample_header, acr_header, avi_header, aif_header, spd_header;
   logic [3:0][55:0] sample_sub, acr_sub, avi_sub, aif_sub, spd_sub;
   logic             sample_ack;
   logic [23:0]      header;
   logic [3:0][55:0] sub;
   logic [7:0]       packet_type;
   logic             infoframe_missed;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic [7:0]       ptype;
      logic [23:0]      hdr;
      logic [3:0][55:0] sb;
   } exp_t;

   exp_t sb_q[$];

   always #5 clk_pixel = ~clk_pixel;

   data_island_scheduler #(.SPD_FRAMES(3)) dut (
      .clk_pixel        (clk_pixel),
      .reset            (reset),
      .frame_start      (frame_start),
      .packet_enable    (packet_enable),
      .sample_valid     (sample_valid),
      .acr_req          (acr_req),
      .sample_header    (sample_header),
      .sample_sub       (sample_sub),
      .acr_header       (acr_header),
      .acr_sub          (acr_sub),
      .avi_header       (avi_header),
      .avi_sub          (avi_sub),
      .aif_header       (aif_header),
      .aif_sub          (aif_sub),
      .spd_header       (spd_header),
      .spd_sub          (spd_sub),
      .sample_ack       (sample_ack),
      .header           (header),
      .sub              (sub),
      .packet_type      (packet_type),
      .infoframe_missed (infoframe_missed)
   );

   // Distinct constant packets per source, keyed by packet type.
   function automatic logic [23:0] hdr_of(input logic [7:0] t);
      case (t)
         8'h02:   return 24'h1F_0F_02;
         8'h01:   return 24'h00_00_01;
         8'h82:   return 24'h0D_02_82;
         8'h84:   return 24'h0A_01_84;
         8'h83:   return 24'h19_01_83;
         default: return 24'h0;
      endcase
   endfunction

   function automatic logic [3:0][55:0] sub_of(input logic [7:0] t);
      logic [55:0] base;
      case (t)
         8'h02:   base = 56'hA0_1234_5678_9A00;
         8'h01:   base = 56'hB0_0000_1800_0000;
         8'h82:   base = 56'hC0_1122_3344_5500;
         8'h84:   base = 56'hD0_6677_8899_AA00;
         8'h83:   base = 56'hE0_4142_4344_4500;
         default: return '0;
      endcase
      return {base + 56'd3, base + 56'd2, base + 56'd1, base};
   endfunction

   task automatic check(input string tag, input logic [223:0] obs, input logic [223:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk_pixel);
      reset = 1'b1;
      frame_start = 1'b0; packet_enable = 1'b0; acr_req = 1'b0; sample_valid = 1'b0;
      repeat (2) @(posedge clk_pixel);
      #1;
      check("reset_header", 224'(header), 224'h0);
      check("reset_sub", 224'(sub), 224'h0);
      check("reset_type", 224'(packet_type), 224'h0);
      check("reset_ack", 224'(sample_ack), 224'h0);
      check("reset_missed", 224'(infoframe_missed), 224'h0);
      @(negedge clk_pixel);
      reset = 1'b0;
   endtask

   task automatic frame(input logic exp_missed);
      @(negedge clk_pixel);
      frame_start = 1'b1;
      @(posedge clk_pixel);
      #1;
      frame_start = 1'b0;
      check("frame_missed", 224'(infoframe_missed), 224'(exp_missed));
   endtask

   task automatic acr_pulse();
      @(negedge clk_pixel);
      acr_req = 1'b1;
      @(posedge clk_pixel);
      #1;
      acr_req = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk_pixel);
   endtask

   // One packet slot, optionally coincident with frame_start / acr_req.
   task automatic slot(input logic [7:0] t, input logic fs, input logic acr,
                       input logic exp_missed);
      exp_t e;
      @(negedge clk_pixel);
      packet_enable = 1'b1;
      frame_start   = fs;
      acr_req       = acr;
      e.ptype = t;
      e.hdr   = hdr_of(t);
      e.sb    = sub_of(t);
      sb_q.push_back(e);
      #1;
      check("slot_ack", 224'(sample_ack), 224'(t == 8'h02));
      @(posedge clk_pixel);
      #1;
      packet_enable = 1'b0;
      frame_start   = 1'b0;
      acr_req       = 1'b0;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      end else begin
         e = sb_q.pop_front();
         check("slot_type", 224'(packet_type), 224'(e.ptype));
         check("slot_header", 224'(header), 224'(e.hdr));
         check("slot_sub", 224'(sub), 224'(e.sb));
         check("slot_missed", 224'(infoframe_missed), 224'(exp_missed));
      end
      idle(2);
   endtask

   initial begin
      sample_header = hdr_of(8'h02); sample_sub = sub_of(8'h02);
      acr_header    = hdr_of(8'h01); acr_sub    = sub_of(8'h01);
      avi_header    = hdr_of(8'h82); avi_sub    = sub_of(8'h82);
      aif_header    = hdr_of(8'h84); aif_sub    = sub_of(8'h84);
      spd_header    = hdr_of(8'h83); spd_sub    = sub_of(8'h83);

      // Basic InfoFrame order after reset, then null.
      do_reset();
      frame(1'b0);
      slot(8'h82, 1'b0, 1'b0, 1'b0);
      slot(8'h84, 1'b0, 1'b0, 1'b0);
      slot(8'h83, 1'b0, 1'b0, 1'b0);
      slot(8'h00, 1'b0, 1'b0, 1'b0);

      // Audio samples starve InfoFrames while valid.
      do_reset();
      frame(1'b0);
      @(negedge clk_pixel);
      sample_valid = 1'b1;
      slot(8'h02, 1'b0, 1'b0, 1'b0);
      slot(8'h02, 1'b0, 1'b0, 1'b0);
      slot(8'h02, 1'b0, 1'b0, 1'b0);
      @(negedge clk_pixel);
      sample_valid = 1'b0;
      slot(8'h82, 1'b0, 1'b0, 1'b0);
      slot(8'h84, 1'b0, 1'b0, 1'b0);
      slot(8'h83, 1'b0, 1'b0, 1'b0);
      slot(8'h00, 1'b0, 1'b0, 1'b0);

      // ACR coalescing, immediate grant, and re-request during a grant.
      do_reset();
      acr_pulse(); idle(1);
      acr_pulse(); idle(1);
      acr_pulse();
      slot(8'h01, 1'b0, 1'b0, 1'b0);
      slot(8'h00, 1'b0, 1'b0, 1'b0);
      slot(8'h01, 1'b0, 1'b1, 1'b0);
      slot(8'h00, 1'b0, 1'b0, 1'b0);
      acr_pulse();
      slot(8'h01, 1'b0, 1'b1, 1'b0);
      slot(8'h01, 1'b0, 1'b0, 1'b0);
      slot(8'h00, 1'b0, 1'b0, 1'b0);

      // SPD every third frame.
      do_reset();
      for (int f = 0; f < 6; f++) begin
         frame(1'b0);
         slot(8'h82, 1'b0, 1'b0, 1'b0);
         slot(8'h84, 1'b0, 1'b0, 1'b0);
         if (f % 3 == 0) slot(8'h83, 1'b0, 1'b0, 1'b0);
         slot(8'h00, 1'b0, 1'b0, 1'b0);
      end

      // Missed InfoFrames: one-cycle pulse, flags kept.
      do_reset();
      frame(1'b0);
      frame(1'b1);
      @(posedge clk_pixel);
      #1;
      check("missed_one_cycle", 224'(infoframe_missed), 224'h0);
      slot(8'h82, 1'b0, 1'b0, 1'b0);
      slot(8'h84, 1'b0, 1'b0, 1'b0);
      slot(8'h83, 1'b0, 1'b0, 1'b0);
      slot(8'h00, 1'b0, 1'b0, 1'b0);

      // frame_start coincident with the slot that drains the last flag.
      do_reset();
      frame(1'b0);
      slot(8'h82, 1'b0, 1'b0, 1'b0);
      slot(8'h84, 1'b0, 1'b0, 1'b0);
      slot(8'h83, 1'b1, 1'b0, 1'b0);
      slot(8'h82, 1'b0, 1'b0, 1'b0);
      slot(8'h84, 1'b0, 1'b0, 1'b0);
      slot(8'h00, 1'b0, 1'b0, 1'b0);

      // Reset mid-activity clears outputs and discards pending requests.
      do_reset();
      frame(1'b0);
      slot(8'h82, 1'b0, 1'b0, 1'b0);
      acr_pulse();
      @(negedge clk_pixel);
      reset = 1'b1;
      packet_enable = 1'b1;
      #1;
      check("reset_pe_ack", 224'(sample_ack), 224'h0);
      @(posedge clk_pixel);
      #1;
      check("midreset_header", 224'(header), 224'h0);
      check("midreset_type", 224'(packet_type), 224'h0);
      @(negedge clk_pixel);
      reset = 1'b0;
      packet_enable = 1'b0;
      slot(8'h00, 1'b0, 1'b0, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/data_island_scheduler.md
# data_island_scheduler

Selects which packet fills each HDMI data-island packet slot. It arbitrates between audio sample packets, Audio Clock Regeneration (ACR), and the three InfoFrames: AVI, Audio InfoFrame and Source Product Description. It sits between the packet generators and the packet assembler in the `clk_pixel` domain. It registers the chosen 24-bit header and four 56-bit subpackets once per slot, and emits a null packet when nothing is pending.

## Interface
- `SPD_FRAMES`, default 1: the SPD InfoFrame is scheduled once every `SPD_FRAMES` video frames (1..255).
- `clk_pixel`  in  1  pixel clock; sole clock.
- `reset`  in  1  synchronous, active-high reset.
- `frame_start`  in  1  one-cycle pulse at the start of each video frame.
- `packet_enable`  in  1  one-cycle pulse from the assembler at the start of each 32-pixel packet slot.
- `sample_valid`  in  1  audio sample packet available (level).
- `acr_req`  in  1  one-cycle ACR request pulse.
- `{sample,acr,avi,aif,spd}_header`  in  24 each  packet headers from the generators.
- `{sample,acr,avi,aif,spd}_sub`  in  4×56 each  subpackets `[3:0]` from the generators.
- `sample_ack`  out  1  pulse: the sample packet was taken this slot.
- `header`  out  24  registered header for the current slot.
- `sub`  out  4×56  registered subpackets for the current slot.
- `packet_type`  out  8  equal to `header[7:0]`; 0x00 means null packet.
- `infoframe_missed`  out  1  pulse: a frame started while an InfoFrame from the previous frame was still unsent.

## Operation
- State:
  - pending flags `avi_p`, `aif_p`, `spd_p`, `acr_p`;
  - 8-bit frame counter `fcnt`, range 0..`SPD_FRAMES`-1.
- On `frame_start`:
  - set `avi_p` and `aif_p`;
  - set `spd_p` when `fcnt`==0;
  - `fcnt` increments and wraps to 0 at `SPD_FRAMES`-1.
- On `acr_req`: set `acr_p`. Repeated requests coalesce into a single pending ACR; there is no counting.
- On each `packet_enable`, choose one source by fixed priority:
  1. sample (`sample_valid`);
  2. ACR (`acr_p` OR `acr_req` this cycle);
  3. AVI (`avi_p`);
  4. AIF (`aif_p`);
  5. SPD (`spd_p`);
  6. null.
- The chosen source's header and sub are registered into `header`/`sub`, and its pending flag is cleared.
- A null slot drives `header`=0 and `sub`=0.
- Choosing sample asserts `sample_ack` for that cycle.
- Without `packet_enable`, `header`/`sub` hold their value and no flags are cleared.
- Audio samples may starve the InfoFrames. This is intended: sample rate × 4 samples/packet leaves slack in every frame at supported rates.

## Timing
- Reset values:
  - `header`=0, `sub`=0, `packet_type`=0;
  - `sample_ack`=0, `infoframe_missed`=0;
  - all pending flags 0, `fcnt`=0.
  - Consequence: SPD is scheduled in the first frame after reset.
- Latency: `packet_enable` in cycle N causes `header`/`sub`/`packet_type` to update at the edge ending cycle N, valid from cycle N+1. `sample_ack` is combinational in cycle N.
- `frame_start` and `packet_enable` in the same cycle:
  - the choice uses the flags as they stood before `frame_start`;
  - the new flags take effect from N+1;
  - `infoframe_missed` (registered, high in N+1) is evaluated on the pre-`frame_start` flags after removing any flag granted in cycle N.
- `acr_req` and `packet_enable` in the same cycle with no sample valid: ACR is granted immediately and `acr_p` stays 0.
- `acr_req` in the same cycle as an ACR grant from an existing `acr_p`: `acr_p` stays set, so one further ACR follows.
- `reset` asserted mid-slot: all state and outputs return to their reset values at the next edge, and pending requests are discarded.
- `packet_enable` during `reset` is ignored.

## Test plan
- Reset, then `frame_start`, then four `packet_enable` pulses with no audio → `packet_type` sequence 0x82, 0x84, 0x83, 0x00. `header`/`sub` match the AVI, AIF, SPD inputs and then zero. `sample_ack` never high.
- `sample_valid`=1 held across three slots after `frame_start` → three 0x02 packets, each with `sample_ack` high on its slot. AVI is deferred to the first slot after `sample_valid` drops.
- Three `acr_req` pulses before one slot → exactly one 0x01 packet, then the next slot is an InfoFrame or null. `acr_req` coincident with `packet_enable` → 0x01 from that slot.
- `SPD_FRAMES`=3, six frames each fully drained → SPD (0x83) appears only in frames 0 and 3. AVI and AIF appear in every frame.
- Two `frame_start` pulses with no intervening `packet_enable` → `infoframe_missed` high for exactly one cycle after the second pulse. Flags remain set, so AVI, AIF, SPD are each sent once afterwards.
- `frame_start`+`packet_enable` in the same cycle with `spd_p` as the only flag → SPD is granted, `infoframe_missed`=0, and the next slots give 0x82, 0x84.
